// File: rtl/calc_dev_nop_fsm.sv
// Calculator device FSM: one command word, then 0..NOPS operands combined into a persistent result.
// Optional build macro CALC_SAT_EN: saturating add/sub steps instead of wrap-around.
module calc_dev_nop_fsm #(
  parameter int DW   = 8,
  parameter int NOPS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic [DW-1:0] din,
  output logic          busy,
  output logic [DW-1:0] dout,
  output logic          drdy,
  output logic          ovf
);

  typedef enum logic [1:0] {IDLE, OPS, EXEC, TX} state_t;

  localparam logic [2:0] NOPS_W = 3'(NOPS);

  state_t        state;
  logic [DW-1:0] result;
  logic [DW-1:0] acc;
  logic [2:0]    n_eff;
  logic [2:0]    idx;
  logic          comb;
  logic          tx;
  logic          clr;
  logic [1:0]    mode;
  logic          acc_ovf;

  // One add/sub step; MSB of the return value is the signed-overflow flag.
  function automatic logic [DW:0] step(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                       input logic sub);
    logic [DW-1:0] s;
    logic          v;
    s = sub ? (a - b) : (a + b);
    v = sub ? ((a[DW-1] != b[DW-1]) && (s[DW-1] != a[DW-1]))
            : ((a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]));
`ifdef CALC_SAT_EN
    if (v) s = a[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
    return {v, s};
  endfunction

  logic [2:0]    cmd_n;
  logic [2:0]    n_sel;
  logic [DW:0]   op_step;
  logic [DW-1:0] base;
  logic [DW:0]   upd;
  logic [DW-1:0] new_result;
  logic          new_ovf;

  always_comb begin
    cmd_n   = din[2:0];
    n_sel   = (cmd_n > NOPS_W) ? NOPS_W : cmd_n;
    op_step = step(acc, din, comb);
    // clr zeroes result and ovf before the mode is applied
    base    = clr ? '0 : result;
    upd     = step(base, acc, mode == 2'b10);
    new_result = base;
    new_ovf    = (clr ? 1'b0 : ovf) | acc_ovf;
    case (mode)
      2'b00: new_result = acc;
      2'b01, 2'b10: begin
        new_result = upd[DW-1:0];
        new_ovf    = new_ovf | upd[DW];
      end
      default: new_result = base;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      drdy    <= 1'b0;
      dout    <= '0;
      ovf     <= 1'b0;
      result  <= '0;
      acc     <= '0;
      n_eff   <= '0;
      idx     <= '0;
      comb    <= 1'b0;
      tx      <= 1'b0;
      clr     <= 1'b0;
      mode    <= 2'b00;
      acc_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          drdy <= 1'b0;
          if (cs) begin
            comb    <= din[3];
            mode    <= din[5:4];
            tx      <= din[6];
            clr     <= din[7];
            n_eff   <= n_sel;
            idx     <= '0;
            acc     <= '0;
            acc_ovf <= 1'b0;
            busy    <= 1'b1;
            state   <= (n_sel != 3'd0) ? OPS : EXEC;
          end
        end
        OPS: begin
          if (idx == 3'd0) begin
            acc <= din;
          end else begin
            acc <= op_step[DW-1:0];
            if (op_step[DW]) acc_ovf <= 1'b1;
          end
          idx <= idx + 3'd1;
          if (idx + 3'd1 == n_eff) state <= EXEC;
        end
        EXEC: begin
          result <= new_result;
          ovf    <= new_ovf;
          if (tx) begin
            dout  <= new_result;
            drdy  <= 1'b1;
            state <= TX;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          drdy  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
